reset_sequencer: RTL

Ordered reset-release controller placed directly downstream of the CDC reset synchronizer. It takes the synchronized reset, holds all of its outputs in reset for a minimum hold period, then releases N_OUT reset outputs one at a time with a fixed gap. This lets FIFO pointer, flag and datapath logic leave reset in a defined order. An optional four-phase soft-reset handshake re-runs the same sequence without touching the global reset.

---
 rtl/reset_sequencer_if.sv | 24 ++
 rtl/reset_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Soft-reset handshake and reset outputs of reset_sequencer, bundled as one port.
// The sequencer connects through the slave modport; the requester uses master.
interface reset_sequencer_if #(
  parameter int N_OUT = 3
);
  logic             soft_rst_req;
  logic             soft_rst_ack;
  logic [N_OUT-1:0] rst_out;
  logic             rst_done;

  modport master (
    output soft_rst_req,
    input  soft_rst_ack,
    input  rst_out,
    input  rst_done
  );

  modport slave (
    input  soft_rst_req,
    output soft_rst_ack,
    output rst_out,
    output rst_done
  );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: hold all outputs, then release them one by one with a fixed gap.
// Define RESET_SEQUENCER_SOFT_RST_EN to build the soft-reset handshake (ASSERT state).
module reset_sequencer #(
  parameter int N_OUT       = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input logic              clk,
  input logic              rst_n,
  reset_sequencer_if.slave bus
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(N_OUT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_DONE,
    S_ASSERT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] rst_out_q, rst_out_d;
  logic             done_q, done_d;
`ifdef RESET_SEQUENCER_SOFT_RST_EN
  logic             ack_q, ack_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
`ifdef RESET_SEQUENCER_SOFT_RST_EN
    ack_d     = ack_q;
`endif
    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          // Outputs release in index order, so a zero-filling left shift clears the next bit.
          rst_out_d = rst_out_q << 1;
          cnt_d     = '0;
          idx_d     = IDX_W'(1);
          if (N_OUT == 1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          rst_out_d = rst_out_q << 1;
          cnt_d     = '0;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
`ifdef RESET_SEQUENCER_SOFT_RST_EN
        if (bus.soft_rst_req) begin
          state_d   = S_ASSERT;
          rst_out_d = '1;
          done_d    = 1'b0;
          ack_d     = 1'b1;
        end
`endif
      end
      S_ASSERT: begin
`ifdef RESET_SEQUENCER_SOFT_RST_EN
        // Dropping the request restarts the full hold/release sequence from scratch.
        if (!bus.soft_rst_req) begin
          state_d = S_HOLD;
          ack_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
`else
        state_d = S_HOLD;
`endif
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
`ifdef RESET_SEQUENCER_SOFT_RST_EN
      ack_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
`ifdef RESET_SEQUENCER_SOFT_RST_EN
      ack_q     <= ack_d;
`endif
    end
  end

  assign bus.rst_out  = rst_out_q;
  assign bus.rst_done = done_q;
`ifdef RESET_SEQUENCER_SOFT_RST_EN
  assign bus.soft_rst_ack = ack_q;
`else
  assign bus.soft_rst_ack = 1'b0;
  logic unused_soft_rst_req;
  assign unused_soft_rst_req = bus.soft_rst_req;
`endif

endmodule
